seg_skid_sreg: RTL and testbench

SEG_SKID_SREG -- requirements
Module: seg_skid_sreg

---
 rtl/seg_skid_sreg.sv | 88 ++++++++
 tb/tb_seg_skid_sreg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg_skid_sreg.sv
// Two-entry skid register pipeline stage: main entry drives outputs, skid absorbs one
// entry of back-pressure so o_ready is registered. Optional counter: SEG_SREG_BUBBLE_CNT_EN.
module seg_skid_sreg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CTRL_WIDTH = 24,
  parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [15:0]           o_bubble_cnt
);

  logic                  r_main_vld, r_skid_vld;
  logic [DATA_WIDTH-1:0] r_main_data, r_skid_data;
  logic [CTRL_WIDTH-1:0] r_main_ctrl, r_skid_ctrl;
  logic                  w_acc, w_rel;

  assign o_ready = !r_skid_vld;
  assign w_acc   = i_valid && !r_skid_vld && i_enable && !i_flush;
  assign w_rel   = r_main_vld && i_ready && i_enable && !i_flush;

  assign o_valid = r_main_vld;
  assign o_data  = r_main_vld ? r_main_data : '0;
  assign o_ctrl  = r_main_vld ? r_main_ctrl : CTRL_NOP;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= CTRL_NOP;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_NOP;
    end else if (i_enable) begin
      if (w_rel) begin
        // skid valid implies o_ready was low, so no accept can collide here
        if (r_skid_vld) begin
          r_main_data <= r_skid_data;
          r_main_ctrl <= r_skid_ctrl;
          r_skid_vld  <= 1'b0;
          r_skid_data <= '0;
          r_skid_ctrl <= CTRL_NOP;
        end else if (w_acc) begin
          r_main_data <= i_data;
          r_main_ctrl <= i_ctrl;
        end else begin
          r_main_vld  <= 1'b0;
          r_main_data <= '0;
          r_main_ctrl <= CTRL_NOP;
        end
      end else if (w_acc) begin
        if (r_main_vld) begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= i_data;
          r_skid_ctrl <= i_ctrl;
        end else begin
          r_main_vld  <= 1'b1;
          r_main_data <= i_data;
          r_main_ctrl <= i_ctrl;
        end
      end
    end
  end

`ifdef SEG_SREG_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_bubble_cnt <= '0;
    else if (i_enable && !r_main_vld && i_ready && r_bubble_cnt != 16'hFFFF)
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end
  assign o_bubble_cnt = r_bubble_cnt;
`else
  assign o_bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_seg_skid_sreg.sv
// Scoreboard bench for seg_skid_sreg: a queue-of-entries reference model plus directed
// scenarios and a randomized phase.
module tb_seg_skid_sreg;
  logic        clk = 1'b0;
  logic        rst, en, fl, vin, rin;
  logic [31:0] din;
  logic [23:0] cin;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [23:0] o_ctrl;
  logic [15:0] o_bubble_cnt;

  typedef struct {logic [31:0] d; logic [23:0] c;} ent_t;
  ent_t        q[$];
  int          m_cnt = 0;
  int          checks = 0, failures = 0;
  bit          mon_en = 0;

`ifdef SEG_SREG_BUBBLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  seg_skid_sreg dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_flush(fl),
    .i_valid(vin), .o_ready(o_ready), .i_data(din), .i_ctrl(cin),
    .o_valid(o_valid), .i_ready(rin), .o_data(o_data), .o_ctrl(o_ctrl),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a stage holds at most two entries in arrival order.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (CNT_ON && en && q.size() == 0 && rin && m_cnt < 16'hFFFF) m_cnt++;
      if (fl) q.delete();
      else if (en) begin
        bit take;
        take = vin && (q.size() < 2);
        if (q.size() > 0 && rin) void'(q.pop_front());
        if (take) q.push_back('{d: din, c: cin});
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
      chk("mon_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0) begin
        chk("mon_data", o_data, q[0].d);
        chk("mon_ctrl", {8'd0, o_ctrl}, {8'd0, q[0].c});
      end else begin
        chk("mon_data_idle", o_data, 32'd0);
        chk("mon_ctrl_idle", {8'd0, o_ctrl}, 32'd0);
      end
      chk("mon_bubble", {16'd0, o_bubble_cnt}, m_cnt[31:0]);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r,
                     input logic e = 1'b1, input logic f = 1'b0, input logic rs = 1'b0);
    vin = v; din = d; cin = d[23:0] ^ 24'hA5C3E1; rin = r; en = e; fl = f; rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 0, 0, 1, 0, 1);
    mon_en = 1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_data", o_data, 32'd0);
    chk("rst_ctrl", {8'd0, o_ctrl}, 32'd0);
    chk("rst_cnt", {16'd0, o_bubble_cnt}, 32'd0);

    // streaming
    cyc(1, 32'h11, 1); chk("strm_0", o_data, 32'h11); chk("strm_rdy0", {31'd0, o_ready}, 32'd1);
    cyc(1, 32'h22, 1); chk("strm_1", o_data, 32'h22); chk("strm_rdy1", {31'd0, o_ready}, 32'd1);
    cyc(1, 32'h33, 1); chk("strm_2", o_data, 32'h33); chk("strm_rdy2", {31'd0, o_ready}, 32'd1);
    cyc(0, 0, 1);      chk("strm_end", {31'd0, o_valid}, 32'd0);

    // back-pressure
    cyc(1, 32'hA, 0); chk("bp_a", o_data, 32'hA);
    cyc(1, 32'hB, 0); chk("bp_hold", o_data, 32'hA); chk("bp_rdy0", {31'd0, o_ready}, 32'd0);
    cyc(0, 0, 0);     chk("bp_hold2", o_data, 32'hA);
    cyc(0, 0, 1);     chk("bp_b", o_data, 32'hB); chk("bp_rdy1", {31'd0, o_ready}, 32'd1);
    cyc(0, 0, 1);     chk("bp_end", {31'd0, o_valid}, 32'd0);

    // flush with both entries full and a same-cycle offer
    cyc(1, 32'hA, 0); cyc(1, 32'hB, 0);
    cyc(1, 32'hC, 0, 1, 1);
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_ctrl", {8'd0, o_ctrl}, 32'd0);
    chk("fl_ready", {31'd0, o_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1); chk("fl_noC", {31'd0, o_valid}, 32'd0);
    end

    // freeze
    cyc(1, 32'hD, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'hE, 1, 0);
      chk("frz_data", o_data, 32'hD);
      chk("frz_ready", {31'd0, o_ready}, 32'd1);
    end
    cyc(0, 0, 0); chk("frz_kept", o_data, 32'hD);
    cyc(0, 0, 1); chk("frz_drain", {31'd0, o_valid}, 32'd0);

    // reset mid-stream with skid full
    cyc(1, 32'h1, 0); cyc(1, 32'h2, 0);
    chk("rm_full", {31'd0, o_ready}, 32'd0);
    cyc(1, 32'h3, 0, 1, 0, 1);
    chk("rm_valid", {31'd0, o_valid}, 32'd0);
    chk("rm_ready", {31'd0, o_ready}, 32'd1);
    chk("rm_cnt", {16'd0, o_bubble_cnt}, 32'd0);
    cyc(1, 32'hF, 0); chk("rm_first", o_data, 32'hF);
    cyc(0, 0, 1);

    // bubble counter
    cyc(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    chk("cnt_10", {16'd0, o_bubble_cnt}, CNT_ON ? 32'd10 : 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 199) == 0));

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
